// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: states, opcodes,
// mux selects, the per-state control word and the state-to-controls map.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC   = 4'd2,
        S_ALU_WB = 4'd3,
        S_MEM_RD = 4'd4,
        S_MEM_WB = 4'd5,
        S_MEM_WR = 4'd6,
        S_BRANCH = 4'd7,
        S_JUMP   = 4'd8
    } state_e;

    typedef enum logic [3:0] {
        C_ILLEGAL, C_RALU, C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_J, C_JAL, C_JR
    } iclass_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_JR    = 6'h08;

    localparam int ALU_OP_BITS = 4;
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_OR  = 4'd2;
    localparam logic [3:0] ALU_LUI = 4'd3;

    localparam logic [1:0] PCSRC_PC4  = 2'd0;
    localparam logic [1:0] PCSRC_BR   = 2'd1;
    localparam logic [1:0] PCSRC_JIDX = 2'd2;
    localparam logic [1:0] PCSRC_REG  = 2'd3;

    localparam logic [1:0] REGDST_RT = 2'd0;
    localparam logic [1:0] REGDST_RD = 2'd1;
    localparam logic [1:0] REGDST_RA = 2'd2;

    localparam logic [1:0] WDSEL_ALU = 2'd0;
    localparam logic [1:0] WDSEL_DM  = 2'd1;
    localparam logic [1:0] WDSEL_PC4 = 2'd2;

    typedef struct packed {
        logic       pc_wr;
        logic [1:0] pc_src;
        logic       ir_wr;
        logic       reg_wr;
        logic [1:0] reg_dst;
        logic [1:0] wd_sel;
        logic       alu_src;
        logic [3:0] alu_op;
        logic       ext_op;
        logic       dm_wr;
        logic       dm_rd;
    } ctl_t;

    // Control word for a state; the ALU controls stay on through ALU_WB because
    // the GRF captures the ALU result directly in that cycle.
    function automatic ctl_t state_ctl(state_e s, iclass_e c, logic [3:0] aop);
        ctl_t k;
        k = '0;
        case (s)
            S_FETCH: begin
                k.pc_wr  = 1'b1;
                k.ir_wr  = 1'b1;
                k.pc_src = PCSRC_PC4;
            end
            S_EXEC, S_ALU_WB: begin
                k.alu_op  = aop;
                k.alu_src = (c != C_RALU);
                k.ext_op  = (c == C_LW) || (c == C_SW);
                if (s == S_ALU_WB) begin
                    k.reg_wr  = 1'b1;
                    k.wd_sel  = WDSEL_ALU;
                    k.reg_dst = (c == C_RALU) ? REGDST_RD : REGDST_RT;
                end
            end
            S_MEM_RD, S_MEM_WR: begin
                k.dm_rd   = (s == S_MEM_RD);
                k.dm_wr   = (s == S_MEM_WR);
                k.alu_src = 1'b1;
                k.alu_op  = ALU_ADD;
                k.ext_op  = 1'b1;
            end
            S_MEM_WB: begin
                k.reg_wr  = 1'b1;
                k.wd_sel  = WDSEL_DM;
                k.reg_dst = REGDST_RT;
            end
            S_BRANCH: begin
                k.alu_op  = ALU_SUB;
                k.alu_src = 1'b0;
                k.ext_op  = 1'b1;
                k.pc_src  = PCSRC_BR;
            end
            S_JUMP: begin
                k.pc_wr  = 1'b1;
                k.pc_src = (c == C_JR) ? PCSRC_REG : PCSRC_JIDX;
                if (c == C_JAL) begin
                    k.reg_wr  = 1'b1;
                    k.reg_dst = REGDST_RA;
                    k.wd_sel  = WDSEL_PC4;
                end
            end
            default: k = '0;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: IR opcode/funct to class and ALU op.
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] func,
    output iclass_e    iclass,
    output logic [3:0] alu_op
);

    always_comb begin
        iclass = C_ILLEGAL;
        alu_op = ALU_ADD;
        case (op)
            OP_RTYPE: begin
                case (func)
                    // An all-zero word (sll $0 nop) behaves as addu to $0.
                    FN_ADDU, FN_SLL: iclass = C_RALU;
                    FN_SUBU: begin
                        iclass = C_RALU;
                        alu_op = ALU_SUB;
                    end
                    FN_JR:   iclass = C_JR;
                    default: iclass = C_ILLEGAL;
                endcase
            end
            OP_ORI: begin
                iclass = C_ORI;
                alu_op = ALU_OR;
            end
            OP_LUI: begin
                iclass = C_LUI;
                alu_op = ALU_LUI;
            end
            OP_LW:  iclass = C_LW;
            OP_SW:  iclass = C_SW;
            OP_BEQ: begin
                iclass = C_BEQ;
                alu_op = ALU_SUB;
            end
            OP_J:    iclass = C_J;
            OP_JAL:  iclass = C_JAL;
            default: iclass = C_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: sequences each instruction over 3-5 states,
// with a DM ready handshake, sticky illegal flag and retired counter.
module mc_ctrl
    import mc_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int ALUOP_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         Op,
    input  logic [5:0]         Func,
    input  logic               Zero,
    input  logic               dm_ready,
    output logic               PCWr,
    output logic [1:0]         PCSrc,
    output logic               IRWr,
    output logic               RegWr,
    output logic [1:0]         RegDst,
    output logic [1:0]         WDSel,
    output logic               ALUSrc,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               EXTOp,
    output logic               DMWr,
    output logic               DMRd,
    output logic               illegal,
    output logic [3:0]         state,
    output logic [CNT_W-1:0]   retired
);

    state_e           state_q, state_d;
    ctl_t             ctl_q, ctl_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             retire;
    iclass_e          iclass;
    logic [3:0]       dec_alu_op;

    mc_decode u_decode (
        .op     (Op),
        .func   (Func),
        .iclass (iclass),
        .alu_op (dec_alu_op)
    );

    always_comb begin
        state_d   = S_FETCH;
        retire    = 1'b0;
        illegal_d = illegal_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (iclass)
                    C_RALU, C_ORI, C_LUI, C_LW, C_SW: state_d = S_EXEC;
                    C_BEQ:                            state_d = S_BRANCH;
                    C_J, C_JAL, C_JR:                 state_d = S_JUMP;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_EXEC: begin
                if (iclass == C_LW)      state_d = S_MEM_RD;
                else if (iclass == C_SW) state_d = S_MEM_WR;
                else                     state_d = S_ALU_WB;
            end
            S_MEM_RD: state_d = dm_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WR: begin
                state_d = dm_ready ? S_FETCH : S_MEM_WR;
                retire  = dm_ready;
            end
            S_ALU_WB, S_MEM_WB, S_BRANCH, S_JUMP: retire = 1'b1;
            default:  state_d = S_FETCH;
        endcase
        retired_d = retired_q + CNT_W'(retire);
        // Outputs are registered from the next state, so they line up with state_q.
        ctl_d     = state_ctl(state_d, iclass, dec_alu_op);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            ctl_q     <= state_ctl(S_FETCH, C_ILLEGAL, ALU_ADD);
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            ctl_q     <= ctl_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
        end
    end

    // Zero is only meaningful while the ALU compares in BRANCH.
    assign PCWr    = ctl_q.pc_wr | ((state_q == S_BRANCH) & Zero);
    assign PCSrc   = ctl_q.pc_src;
    assign IRWr    = ctl_q.ir_wr;
    assign RegWr   = ctl_q.reg_wr;
    assign RegDst  = ctl_q.reg_dst;
    assign WDSel   = ctl_q.wd_sel;
    assign ALUSrc  = ctl_q.alu_src;
    assign ALUOp   = ALUOP_W'(ctl_q.alu_op);
    assign EXTOp   = ctl_q.ext_op;
    assign DMWr    = ctl_q.dm_wr;
    assign DMRd    = ctl_q.dm_rd;
    assign illegal = illegal_q;
    assign state   = state_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: table of instructions with expected per-instruction
// results, plus hand-written reset and mid-store reset sequences.
module tb_mc_ctrl;
    import mc_pkg::*;

    logic        clk;
    logic        reset;
    logic [5:0]  op;
    logic [5:0]  func;
    logic        zero;
    logic        dm_ready;
    logic        pcwr;
    logic [1:0]  pcsrc;
    logic        irwr;
    logic        regwr;
    logic [1:0]  regdst;
    logic [1:0]  wdsel;
    logic        alusrc;
    logic [3:0]  aluop;
    logic        extop;
    logic        dmwr;
    logic        dmrd;
    logic        illegal;
    logic [3:0]  state;
    logic [31:0] retired;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    mc_ctrl #(.CNT_W(32), .ALUOP_W(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .Op       (op),
        .Func     (func),
        .Zero     (zero),
        .dm_ready (dm_ready),
        .PCWr     (pcwr),
        .PCSrc    (pcsrc),
        .IRWr     (irwr),
        .RegWr    (regwr),
        .RegDst   (regdst),
        .WDSel    (wdsel),
        .ALUSrc   (alusrc),
        .ALUOp    (aluop),
        .EXTOp    (extop),
        .DMWr     (dmwr),
        .DMRd     (dmrd),
        .illegal  (illegal),
        .state    (state),
        .retired  (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] instr;
        logic        zero;
        int          wait_n;
        int          cycles;
        logic [13:0] last_w;
        logic [5:0]  alu_w;
        int          regwr_n;
        int          dm_n;
        int          ret_inc;
        logic        ill;
    } vec_t;

    vec_t vecs[17];

    function automatic logic [13:0] mkc(logic [3:0] st, logic pw, logic [1:0] ps,
                                        logic rw, logic [1:0] rd, logic [1:0] wd,
                                        logic dw, logic dr);
        return {st, pw, ps, rw, rd, wd, dw, dr};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Runs one instruction from a FETCH negedge to the next FETCH negedge.
    task automatic run_vec(input vec_t v, input int idx);
        int          cycles;
        int          waited;
        int          regwr_n;
        int          dm_n;
        logic [13:0] last_w;
        logic [5:0]  alu_w;
        logic [31:0] ret0;
        string       tag;
        op       = v.instr[31:26];
        func     = v.instr[5:0];
        zero     = (v.instr[31:26] == OP_BEQ) ? v.zero : 1'($urandom_range(0, 1));
        ret0     = retired;
        exp_q.push_back(32'(v.cycles));
        exp_q.push_back(32'(v.last_w));
        exp_q.push_back(32'(v.alu_w));
        exp_q.push_back(32'(v.regwr_n));
        exp_q.push_back(32'(v.dm_n));
        exp_q.push_back(32'(v.ret_inc));
        exp_q.push_back(32'(v.ill));
        cycles = 0; waited = 0; regwr_n = 0; dm_n = 0; last_w = '0; alu_w = '0;
        do begin
            if (state == S_EXEC || state == S_BRANCH) alu_w = {aluop, alusrc, extop};
            if (state != S_FETCH) last_w = {state, pcwr, pcsrc, regwr, regdst, wdsel, dmwr, dmrd};
            regwr_n += int'(regwr);
            dm_n    += int'(dmwr | dmrd);
            if (state == S_MEM_RD || state == S_MEM_WR) begin
                dm_ready = (waited >= v.wait_n);
                waited++;
            end else begin
                dm_ready = 1'($urandom_range(0, 1));
            end
            cycles++;
            @(negedge clk);
        end while (state != S_FETCH && cycles < 30);
        dm_ready = 1'b0;
        tag = $sformatf("v%0d", idx);
        check({tag, "_cycles"},  32'(cycles),         exp_q.pop_front());
        check({tag, "_last"},    32'(last_w),         exp_q.pop_front());
        check({tag, "_alu"},     32'(alu_w),          exp_q.pop_front());
        check({tag, "_regwr_n"}, 32'(regwr_n),        exp_q.pop_front());
        check({tag, "_dm_n"},    32'(dm_n),           exp_q.pop_front());
        check({tag, "_retired"}, retired - ret0,      exp_q.pop_front());
        check({tag, "_illegal"}, 32'(illegal),        exp_q.pop_front());
    endtask

    initial begin
        int cnt;
        vecs[0]  = '{32'h00221821, 1'b0, 0, 4, mkc(S_ALU_WB, 0, 0, 1, 1, 0, 0, 0), {4'd0, 1'b0, 1'b0}, 1, 0, 1, 1'b0};
        vecs[1]  = '{32'h00221823, 1'b0, 0, 4, mkc(S_ALU_WB, 0, 0, 1, 1, 0, 0, 0), {4'd1, 1'b0, 1'b0}, 1, 0, 1, 1'b0};
        vecs[2]  = '{32'h342200FF, 1'b0, 0, 4, mkc(S_ALU_WB, 0, 0, 1, 0, 0, 0, 0), {4'd2, 1'b1, 1'b0}, 1, 0, 1, 1'b0};
        vecs[3]  = '{32'h3C011234, 1'b0, 0, 4, mkc(S_ALU_WB, 0, 0, 1, 0, 0, 0, 0), {4'd3, 1'b1, 1'b0}, 1, 0, 1, 1'b0};
        vecs[4]  = '{32'h8C220004, 1'b0, 2, 7, mkc(S_MEM_WB, 0, 0, 1, 0, 1, 0, 0), {4'd0, 1'b1, 1'b1}, 1, 3, 1, 1'b0};
        vecs[5]  = '{32'hAC220008, 1'b0, 1, 5, mkc(S_MEM_WR, 0, 0, 0, 0, 0, 1, 0), {4'd0, 1'b1, 1'b1}, 0, 2, 1, 1'b0};
        vecs[6]  = '{32'hAC220008, 1'b0, 0, 4, mkc(S_MEM_WR, 0, 0, 0, 0, 0, 1, 0), {4'd0, 1'b1, 1'b1}, 0, 1, 1, 1'b0};
        vecs[7]  = '{32'h10220003, 1'b1, 0, 3, mkc(S_BRANCH, 1, 1, 0, 0, 0, 0, 0), {4'd1, 1'b0, 1'b1}, 0, 0, 1, 1'b0};
        vecs[8]  = '{32'h10220003, 1'b0, 0, 3, mkc(S_BRANCH, 0, 1, 0, 0, 0, 0, 0), {4'd1, 1'b0, 1'b1}, 0, 0, 1, 1'b0};
        vecs[9]  = '{32'h08000010, 1'b0, 0, 3, mkc(S_JUMP,   1, 2, 0, 0, 0, 0, 0), 6'd0, 0, 0, 1, 1'b0};
        vecs[10] = '{32'h0C000C00, 1'b0, 0, 3, mkc(S_JUMP,   1, 2, 1, 2, 2, 0, 0), 6'd0, 1, 0, 1, 1'b0};
        vecs[11] = '{32'h03E00008, 1'b0, 0, 3, mkc(S_JUMP,   1, 3, 0, 0, 0, 0, 0), 6'd0, 0, 0, 1, 1'b0};
        vecs[12] = '{32'h00000000, 1'b0, 0, 4, mkc(S_ALU_WB, 0, 0, 1, 1, 0, 0, 0), {4'd0, 1'b0, 1'b0}, 1, 0, 1, 1'b0};
        vecs[13] = '{32'hFC000000, 1'b0, 0, 2, mkc(S_DECODE, 0, 0, 0, 0, 0, 0, 0), 6'd0, 0, 0, 0, 1'b1};
        vecs[14] = '{32'h00221825, 1'b0, 0, 2, mkc(S_DECODE, 0, 0, 0, 0, 0, 0, 0), 6'd0, 0, 0, 0, 1'b1};
        vecs[15] = '{32'h00221821, 1'b0, 0, 4, mkc(S_ALU_WB, 0, 0, 1, 1, 0, 0, 0), {4'd0, 1'b0, 1'b0}, 1, 0, 1, 1'b1};
        vecs[16] = '{32'h00221821, 1'b0, 0, 4, mkc(S_ALU_WB, 0, 0, 1, 1, 0, 0, 0), {4'd0, 1'b0, 1'b0}, 1, 0, 1, 1'b0};

        reset = 1'b0; op = '0; func = '0; zero = 1'b0; dm_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_state",   32'(state),   32'(S_FETCH));
        check("rst_retired", retired,      32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        check("rst_dmwr",    32'(dmwr),    32'd0);
        check("rst_regwr",   32'(regwr),   32'd0);
        reset = 1'b1;
        check("fetch_irwr",  32'(irwr),    32'd1);
        check("fetch_pcwr",  32'(pcwr),    32'd1);
        check("fetch_pcsrc", 32'(pcsrc),   32'd0);

        for (int i = 0; i < 16; i++) run_vec(vecs[i], i);

        // Store stalled in MEM_WR, then reset lands mid-cycle.
        op = 6'h2B; func = 6'h08; dm_ready = 1'b0; cnt = 0;
        while (state != S_MEM_WR && cnt < 10) begin
            @(negedge clk);
            cnt++;
        end
        @(negedge clk);
        check("swr_state",   32'(state), 32'(S_MEM_WR));
        check("swr_dmwr_on", 32'(dmwr),  32'd1);
        #2 reset = 1'b0;
        #1;
        check("swr_dmwr_off", 32'(dmwr),    32'd0);
        check("swr_state_rst", 32'(state),  32'(S_FETCH));
        check("swr_retired",  retired,      32'd0);
        check("swr_illegal",  32'(illegal), 32'd0);
        check("swr_regwr",    32'(regwr),   32'd0);
        @(negedge clk);
        check("swr_hold", 32'(state), 32'(S_FETCH));
        reset = 1'b1;
        run_vec(vecs[16], 16);
        check("post_rst_retired", retired, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle control FSM for the MIPS datapath: GRF, ALU, DM, EXT and IFU, with an added instruction register (IR).
- Replaces the combinational `ctrl` decoder. One instruction is sequenced over 3–5 states, with per-state write enables so that GRF, DM, IR and PC update only in their designated cycle.
- Supports a DM ready handshake and a retired-instruction counter.

Parameters:
- CNT_W, 32, width of retired-instruction counter.
- ALUOP_W, 4, ALUOp width; the ALU encoding is fixed in the package.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- Op  in  6  IR[31:26].
- Func  in  6  IR[5:0].
- Zero  in  1  ALU zero flag, valid during the BRANCH state.
- dm_ready  in  1  DM access complete; sampled in MEM_RD/MEM_WR.
- PCWr  out  1  PC write enable.
- PCSrc  out  2  0 = PC+4, 1 = PC+4+(ext<<2), 2 = {PC[31:28],index,00}, 3 = RD1.
- IRWr  out  1  IR load enable.
- RegWr  out  1  GRF write enable.
- RegDst  out  2  0 = rt, 1 = rd, 2 = $31.
- WDSel  out  2  0 = ALU result, 1 = DM read data, 2 = PC+4.
- ALUSrc  out  1  0 = RD2, 1 = ext.
- ALUOp  out  ALUOP_W  ALU operation.
- EXTOp  out  1  1 = sign-extend, 0 = zero-extend.
- DMWr  out  1  DM write strobe.
- DMRd  out  1  DM read strobe.
- illegal  out  1  sticky flag: an unsupported opcode was decoded.
- state  out  4  current state, for debug.
- retired  out  CNT_W  count of completed instructions.

Behaviour:
- Reset (reset==0, asynchronous): state=FETCH; retired=0; illegal=0.
- All outputs are Moore, decoded from state plus the latched Op/Func. Every enable and strobe not listed for a state is 0; the default mux selects are 0.
- Supported instructions (Op/Func in hex):
  - addu 00/21, subu 00/23, jr 00/08
  - ori 0D, lui 0F, lw 23, sw 2B, beq 04, j 02, jal 03
  - nop is sll $0 (all zero) and is treated as addu to $0.
- ALUOp encodings: ADD=0, SUB=1, OR=2, LUI=3 (B<<16).
- States and actions:
  - FETCH: IRWr=1, PCWr=1, PCSrc=0 → DECODE.
  - DECODE: GRF read, no writes. Next state:
    - addu/subu/ori/lui/lw/sw → EXEC
    - beq → BRANCH
    - j/jal/jr → JUMP
    - other → FETCH with illegal set.
  - EXEC: ALUOp by instruction. ALUSrc=1 and EXTOp=sign for lw/sw; EXTOp=zero for ori/lui. Next state: lw → MEM_RD, sw → MEM_WR, else → ALU_WB.
  - ALU_WB: RegWr=1, WDSel=0, RegDst=1 for R-type else 0 → FETCH; retired++.
  - MEM_RD: DMRd=1, ALUSrc=1, ALUOp=ADD. Hold while dm_ready=0; on dm_ready=1 → MEM_WB.
  - MEM_WB: RegWr=1, WDSel=1, RegDst=0 → FETCH; retired++.
  - MEM_WR: DMWr=1, ALUSrc=1, ALUOp=ADD. Hold while dm_ready=0; on dm_ready=1 → FETCH; retired++.
  - BRANCH: ALUOp=SUB, ALUSrc=0, EXTOp=sign, PCWr=Zero, PCSrc=1 → FETCH; retired++.
    - The IFU branch target adder uses PC+4 captured at FETCH.
  - JUMP: PCWr=1, PCSrc=2 for j/jal, 3 for jr. jal additionally sets RegWr=1, RegDst=2, WDSel=2 → FETCH; retired++.
- Latencies in cycles: R-type/ori/lui 4; lw 5+wait; sw 4+wait; beq 3; j/jal/jr 3.
- Op/Func are taken from the IR. The FSM does not re-decode mid-instruction because the IR changes only in FETCH.
- Illegal instruction: no GRF/DM/PC write beyond the FETCH increment; retired is not incremented; illegal stays 1 until reset.
- retired wraps modulo 2^CNT_W.
- Reset asserted mid-instruction (e.g. in MEM_WR): DMWr and all other enables drop combinationally with state→FETCH. No partial write occurs after the reset edge.
- dm_ready is ignored outside the MEM states.
- Unreachable state encodings → FETCH on the next clock.

Decomposition:
- Package `mc_pkg`: state enum (FETCH, DECODE, EXEC, ALU_WB, MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP); opcode and funct constants; ALUOp codes; PCSrc/RegDst/WDSel select constants.
- Sub-module `mc_decode`: combinational Op/Func → instruction class and ALUOp. The FSM and counters stay in `mc_ctrl`.

Test Plan:
- Reset released, IR = addu $3,$1,$2 (0x00221821): states FETCH→DECODE→EXEC→ALU_WB. RegWr=1 only in cycle 4 with RegDst=1, ALUOp=0. retired=1.
- lw (0x8C220004) with dm_ready low for 2 cycles: DMRd=1 held for 3 cycles, then MEM_WB with WDSel=1, RegWr=1. Total 7 cycles; retired increments once.
- beq with Zero=1 then Zero=0: PCWr=1, PCSrc=1 in BRANCH for the first case; PCWr=0 for the second. Each takes 3 cycles.
- jal 0x0C000C00: JUMP state has PCWr=1, PCSrc=2, RegWr=1, RegDst=2, WDSel=2. jr $31 (0x03E00008) gives PCSrc=3.
- Op=0x3F: DECODE→FETCH, illegal=1 and sticky, retired unchanged, no RegWr/DMWr.
- sw in MEM_WR with dm_ready=0, then reset driven 0 asynchronously: DMWr=0 immediately, state=FETCH, retired=0, illegal=0. After release, normal fetch resumes.
